// File: rtl/integrator_supervisor_pkg.sv
// Shared types for the integrator supervisor: state encoding,
// trip_cause bit positions and the default minimum window.
package integrator_supervisor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_ARMING,
    S_ACTIVE,
    S_TRIPPED
  } sup_state_e;

  localparam int unsigned CAUSE_OVER_THR = 0;
  localparam int unsigned CAUSE_OVERFLOW = 1;
  localparam int unsigned CAUSE_UNDERFLOW = 2;
  localparam int unsigned CAUSE_EXT_TRIP = 3;
  localparam int unsigned CAUSE_BAD_CFG = 4;
  localparam int unsigned CAUSE_TIMEOUT = 5;
  localparam int unsigned CAUSE_W = 6;

  localparam logic [31:0] MIN_WINDOW_DEF = 32'd2048;

endpackage

// File: rtl/integrator_supervisor.sv
// Integrator supervisor: validates/latches config, arms the integrator,
// watches status flags and latches a sticky safe shutdown.
//
// Ports: clk, aresetn (sync, active-low); start, window_in[31:0],
// threshold_in[14:0], ext_trip, integ_setup_done, integ_over_threshold,
// integ_err_overflow, integ_err_underflow in; integ_enable,
// integ_window[31:0], integ_threshold[14:0], running, shutdown,
// trip_cause[5:0] out (all registered).
// Option: INTEGRATOR_SUPERVISOR_SETUP_TIMEOUT_EN adds an ARMING timeout.
module integrator_supervisor
  import integrator_supervisor_pkg::*;
#(
  parameter logic [31:0] SETUP_TIMEOUT = 32'd1_000_000,
  parameter logic [31:0] MIN_WINDOW = MIN_WINDOW_DEF
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] window_in,
  input  logic [14:0] threshold_in,
  input  logic        ext_trip,
  input  logic        integ_setup_done,
  input  logic        integ_over_threshold,
  input  logic        integ_err_overflow,
  input  logic        integ_err_underflow,
  output logic        integ_enable,
  output logic [31:0] integ_window,
  output logic [14:0] integ_threshold,
  output logic        running,
  output logic        shutdown,
  output logic [5:0]  trip_cause
);

  sup_state_e         state_q, state_d;
  logic [31:0]        win_q, win_d;
  logic [14:0]        thr_q, thr_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               en_q, en_d;
  logic               run_q, run_d;
  logic               shut_q, shut_d;
  logic [CAUSE_W-1:0] trips;
  logic               timed_out;

`ifdef INTEGRATOR_SUPERVISOR_SETUP_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;

  assign timed_out = (timer_q == 32'd0);

  always_comb begin
    timer_d = timer_q;
    if (state_d == S_ARMING && state_q != S_ARMING) begin
      timer_d = SETUP_TIMEOUT - 32'd1;
    end else if (state_q == S_ARMING && timer_q != 32'd0) begin
      timer_d = timer_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) timer_q <= 32'd0;
    else          timer_q <= timer_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  // Integrator flags only count once the integrator is enabled.
  always_comb begin
    trips = '0;
    trips[CAUSE_EXT_TRIP] = ext_trip;
    if (state_q == S_ARMING || state_q == S_ACTIVE) begin
      trips[CAUSE_OVER_THR] = integ_over_threshold;
      trips[CAUSE_OVERFLOW] = integ_err_overflow;
      trips[CAUSE_UNDERFLOW] = integ_err_underflow;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    thr_d   = thr_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (|trips) begin
          state_d = S_TRIPPED;
          cause_d = cause_q | trips;
        end else if (start) begin
          if (window_in < MIN_WINDOW) begin
            state_d = S_TRIPPED;
            cause_d[CAUSE_BAD_CFG] = 1'b1;
          end else begin
            state_d = S_CONFIG;
            win_d   = window_in;
            thr_d   = threshold_in;
          end
        end
      end
      S_CONFIG: begin
        if (|trips) begin
          state_d = S_TRIPPED;
          cause_d = cause_q | trips;
        end else begin
          state_d = S_ARMING;
        end
      end
      S_ARMING: begin
        if (|trips) begin
          state_d = S_TRIPPED;
          cause_d = cause_q | trips;
        end else if (integ_setup_done) begin
          state_d = S_ACTIVE;
        end else if (timed_out) begin
          state_d = S_TRIPPED;
          cause_d[CAUSE_TIMEOUT] = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (|trips) begin
          state_d = S_TRIPPED;
          cause_d = cause_q | trips;
        end
      end
      S_TRIPPED: begin
        state_d = S_TRIPPED;
      end
      default: begin
        state_d = S_TRIPPED;
      end
    endcase
    // Outputs follow the next state so they are registered with it.
    en_d   = (state_d == S_ARMING) || (state_d == S_ACTIVE);
    run_d  = (state_d == S_ACTIVE);
    shut_d = (state_d == S_TRIPPED);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      thr_q   <= '0;
      cause_q <= '0;
      en_q    <= 1'b0;
      run_q   <= 1'b0;
      shut_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      thr_q   <= thr_d;
      cause_q <= cause_d;
      en_q    <= en_d;
      run_q   <= run_d;
      shut_q  <= shut_d;
    end
  end

  assign integ_enable    = en_q;
  assign integ_window    = win_q;
  assign integ_threshold = thr_q;
  assign running         = run_q;
  assign shutdown        = shut_q;
  assign trip_cause      = cause_q;

endmodule

// File: tb/tb_integrator_supervisor.sv
// Directed self-checking bench for integrator_supervisor.
// Each task drives one scenario and checks outputs 1ns after the edge.
module tb_integrator_supervisor;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [31:0] window_in;
  logic [14:0] threshold_in;
  logic        ext_trip;
  logic        integ_setup_done;
  logic        integ_over_threshold;
  logic        integ_err_overflow;
  logic        integ_err_underflow;
  logic        integ_enable;
  logic [31:0] integ_window;
  logic [14:0] integ_threshold;
  logic        running;
  logic        shutdown;
  logic [5:0]  trip_cause;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  integrator_supervisor #(
    .SETUP_TIMEOUT(32'd16),
    .MIN_WINDOW(32'd2048)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .start(start),
    .window_in(window_in),
    .threshold_in(threshold_in),
    .ext_trip(ext_trip),
    .integ_setup_done(integ_setup_done),
    .integ_over_threshold(integ_over_threshold),
    .integ_err_overflow(integ_err_overflow),
    .integ_err_underflow(integ_err_underflow),
    .integ_enable(integ_enable),
    .integ_window(integ_window),
    .integ_threshold(integ_threshold),
    .running(running),
    .shutdown(shutdown),
    .trip_cause(trip_cause)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0;
    window_in = 0;
    threshold_in = 0;
    ext_trip = 0;
    integ_setup_done = 0;
    integ_over_threshold = 0;
    integ_err_overflow = 0;
    integ_err_underflow = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    aresetn = 0;
    step();
    step();
    checks++;
    if ({integ_enable, running, shutdown, trip_cause,
         integ_window, integ_threshold} !== 56'd0) begin
      failures++;
      $display("FAIL reset: en=%b run=%b sd=%b cause=%b win=%0d thr=%0d, want all 0",
               integ_enable, running, shutdown, trip_cause,
               integ_window, integ_threshold);
    end
    aresetn = 1;
  endtask

  // Start with a legal window and leave the DUT in ARMING.
  task automatic arm(input logic [31:0] w, input logic [14:0] t);
    start = 1;
    window_in = w;
    threshold_in = t;
    step();
    start = 0;
    step();
  endtask

  task automatic test_nominal();
    test_reset();
    start = 1;
    window_in = 32'd4096;
    threshold_in = 15'd100;
    step();
    start = 0;
    window_in = 32'd9999;
    threshold_in = 15'd7;
    checks++;
    if (integ_enable !== 1'b0 || integ_window !== 32'd4096 ||
        integ_threshold !== 15'd100) begin
      failures++;
      $display("FAIL config: en=%b win=%0d thr=%0d, want 0/4096/100",
               integ_enable, integ_window, integ_threshold);
    end
    step();
    checks++;
    if (integ_enable !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL arming: en=%b run=%b, want 1/0", integ_enable, running);
    end
    for (int i = 2; i < 10; i++) step();
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL arming_wait: run=%b, want 0", running);
    end
    integ_setup_done = 1;
    step();
    integ_setup_done = 0;
    checks++;
    if (running !== 1'b1 || integ_enable !== 1'b1 || shutdown !== 1'b0) begin
      failures++;
      $display("FAIL active: run=%b en=%b sd=%b, want 1/1/0",
               running, integ_enable, shutdown);
    end
    start = 1;
    window_in = 32'd5000;
    threshold_in = 15'd55;
    step();
    start = 0;
    checks++;
    if (integ_window !== 32'd4096 || integ_threshold !== 15'd100 ||
        running !== 1'b1) begin
      failures++;
      $display("FAIL start_ignored: win=%0d thr=%0d run=%b, want 4096/100/1",
               integ_window, integ_threshold, running);
    end
  endtask

  task automatic test_bad_window();
    logic en_seen;
    test_reset();
    en_seen = 0;
    start = 1;
    window_in = 32'd2047;
    threshold_in = 15'd3;
    step();
    start = 0;
    checks++;
    if (trip_cause !== 6'b010000 || shutdown !== 1'b1 ||
        integ_window !== 32'd0) begin
      failures++;
      $display("FAIL bad_window: cause=%b sd=%b win=%0d, want 010000/1/0",
               trip_cause, shutdown, integ_window);
    end
    for (int i = 0; i < 5; i++) begin
      en_seen = en_seen | integ_enable;
      step();
    end
    checks++;
    if (en_seen !== 1'b0) begin
      failures++;
      $display("FAIL bad_window_en: enable seen=%b, want 0", en_seen);
    end
    // Boundary: exactly MIN_WINDOW is legal.
    test_reset();
    arm(32'd2048, 15'd1);
    checks++;
    if (integ_enable !== 1'b1 || shutdown !== 1'b0 ||
        integ_window !== 32'd2048) begin
      failures++;
      $display("FAIL min_window: en=%b sd=%b win=%0d, want 1/0/2048",
               integ_enable, shutdown, integ_window);
    end
  endtask

  task automatic test_multi_trip();
    test_reset();
    arm(32'd4096, 15'd100);
    integ_setup_done = 1;
    step();
    integ_setup_done = 0;
    integ_over_threshold = 1;
    ext_trip = 1;
    step();
    integ_over_threshold = 0;
    ext_trip = 0;
    checks++;
    if (trip_cause !== 6'b001001 || running !== 1'b0 ||
        shutdown !== 1'b1 || integ_enable !== 1'b0) begin
      failures++;
      $display("FAIL multi_trip: cause=%b run=%b sd=%b en=%b, want 001001/0/1/0",
               trip_cause, running, shutdown, integ_enable);
    end
    integ_err_overflow = 1;
    start = 1;
    window_in = 32'd4096;
    step();
    step();
    integ_err_overflow = 0;
    start = 0;
    checks++;
    if (trip_cause !== 6'b001001 || shutdown !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL frozen_cause: cause=%b sd=%b run=%b, want 001001/1/0",
               trip_cause, shutdown, running);
    end
  endtask

  task automatic test_priority();
    // ext_trip beats start in IDLE; config not latched.
    test_reset();
    ext_trip = 1;
    start = 1;
    window_in = 32'd8192;
    step();
    ext_trip = 0;
    start = 0;
    checks++;
    if (trip_cause !== 6'b001000 || shutdown !== 1'b1 ||
        integ_window !== 32'd0) begin
      failures++;
      $display("FAIL idle_trip: cause=%b sd=%b win=%0d, want 001000/1/0",
               trip_cause, shutdown, integ_window);
    end
    // Integrator flags ignored in IDLE.
    test_reset();
    integ_err_underflow = 1;
    step();
    integ_err_underflow = 0;
    checks++;
    if (shutdown !== 1'b0 || trip_cause !== 6'd0) begin
      failures++;
      $display("FAIL idle_flag_ignored: sd=%b cause=%b, want 0/000000",
               shutdown, trip_cause);
    end
    // Flag beats setup_done in ARMING; two flags at once.
    arm(32'd4096, 15'd9);
    integ_setup_done = 1;
    integ_err_overflow = 1;
    integ_err_underflow = 1;
    step();
    clear_inputs();
    checks++;
    if (trip_cause !== 6'b000110 || running !== 1'b0 || shutdown !== 1'b1) begin
      failures++;
      $display("FAIL arming_trip: cause=%b run=%b sd=%b, want 000110/0/1",
               trip_cause, running, shutdown);
    end
  endtask

  task automatic test_timeout();
    int n;
`ifdef INTEGRATOR_SUPERVISOR_SETUP_TIMEOUT_EN
    test_reset();
    arm(32'd4096, 15'd100);
    n = 0;
    while (shutdown !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 16 || trip_cause !== 6'b100000 || integ_enable !== 1'b0) begin
      failures++;
      $display("FAIL timeout: cycles=%0d cause=%b en=%b, want 16/100000/0",
               n, trip_cause, integ_enable);
    end
    // setup_done on the zero-count cycle wins over timeout.
    test_reset();
    arm(32'd4096, 15'd100);
    for (int i = 0; i < 15; i++) step();
    integ_setup_done = 1;
    step();
    integ_setup_done = 0;
    checks++;
    if (running !== 1'b1 || shutdown !== 1'b0 || trip_cause !== 6'd0) begin
      failures++;
      $display("FAIL timeout_edge: run=%b sd=%b cause=%b, want 1/0/000000",
               running, shutdown, trip_cause);
    end
`else
    test_reset();
    arm(32'd4096, 15'd100);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      n++;
    end
    checks++;
    if (integ_enable !== 1'b1 || shutdown !== 1'b0 || running !== 1'b0 ||
        trip_cause !== 6'd0) begin
      failures++;
      $display("FAIL no_timeout: after %0d en=%b sd=%b run=%b cause=%b, want 1/0/0/0",
               n, integ_enable, shutdown, running, trip_cause);
    end
`endif
  endtask

  task automatic test_reset_tripped();
    test_reset();
    arm(32'd4096, 15'd100);
    ext_trip = 1;
    step();
    ext_trip = 0;
    aresetn = 0;
    step();
    aresetn = 1;
    checks++;
    if ({integ_enable, running, shutdown, trip_cause,
         integ_window, integ_threshold} !== 56'd0) begin
      failures++;
      $display("FAIL reset_tripped: en=%b run=%b sd=%b cause=%b win=%0d thr=%0d, want 0",
               integ_enable, running, shutdown, trip_cause,
               integ_window, integ_threshold);
    end
    arm(32'd3000, 15'd42);
    integ_setup_done = 1;
    step();
    integ_setup_done = 0;
    checks++;
    if (running !== 1'b1 || integ_window !== 32'd3000 ||
        integ_threshold !== 15'd42 || shutdown !== 1'b0) begin
      failures++;
      $display("FAIL rearm: run=%b win=%0d thr=%0d sd=%b, want 1/3000/42/0",
               running, integ_window, integ_threshold, shutdown);
    end
  endtask

  initial begin
    aresetn = 0;
    clear_inputs();
    test_reset();
    test_nominal();
    test_bad_window();
    test_multi_trip();
    test_priority();
    test_timeout();
    test_reset_tripped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/integrator_supervisor.md
INTEGRATOR_SUPERVISOR -- requirements
Module: integrator_supervisor

Interface
REQ-001 SHALL have parameter SETUP_TIMEOUT, default 32'd1_000_000, meaning max cycles in ARMING awaiting integ_setup_done.
REQ-002 SHALL have parameter MIN_WINDOW, default 32'd2048, meaning smallest legal integration window.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to configure and arm the integrator.
REQ-006 SHALL have port window_in, input, 32 bits: requested window in samples.
REQ-007 SHALL have port threshold_in, input, 15 bits: requested average threshold.
REQ-008 SHALL have port ext_trip, input, 1 bit: external shutdown request, level.
REQ-009 SHALL have port integ_setup_done, input, 1 bit: integrator ready.
REQ-010 SHALL have ports integ_over_threshold, integ_err_overflow and integ_err_underflow, each input, 1 bit: integrator status flags.
REQ-011 SHALL have port integ_enable, output, 1 bit: enable to integrator.
REQ-012 SHALL have port integ_window, output, 32 bits: latched window to integrator.
REQ-013 SHALL have port integ_threshold, output, 15 bits: latched threshold to integrator.
REQ-014 SHALL have port running, output, 1 bit: high in ACTIVE only.
REQ-015 SHALL have port shutdown, output, 1 bit: sticky safe-shutdown command.
REQ-016 SHALL have port trip_cause, output, 6 bits: sticky cause flags with bits [0] over_threshold, [1] overflow, [2] underflow, [3] ext_trip, [4] bad config, [5] setup timeout.

Function
REQ-017 SHALL implement states IDLE, CONFIG, ARMING, ACTIVE and TRIPPED, all outputs registered.
REQ-018 In IDLE, start=1 with window_in >= MIN_WINDOW SHALL latch window_in and threshold_in into integ_window and integ_threshold, then go to CONFIG.
REQ-019 In IDLE, start=1 with window_in < MIN_WINDOW SHALL set trip_cause[4] and go to TRIPPED.
REQ-020 start SHALL be ignored outside IDLE; integ_window and integ_threshold SHALL NOT change outside the IDLE->CONFIG transition.
REQ-021 CONFIG SHALL last exactly 1 cycle, with integ_enable low, then go to ARMING (config stable one cycle before enable).
REQ-022 integ_enable SHALL be high in ARMING and ACTIVE and low in all other states.
REQ-023 ARMING SHALL go to ACTIVE on the cycle integ_setup_done is sampled high.
REQ-024 In IDLE, CONFIG, ARMING and ACTIVE, any trip source sampled high at edge N SHALL give TRIPPED state, shutdown=1 and the corresponding cause bits all visible after edge N (1-cycle latency).
REQ-025 Trip sources are ext_trip in all four states, and integ_over_threshold, integ_err_overflow and integ_err_underflow in ARMING and ACTIVE only.
REQ-026 Simultaneous trip sources SHALL set all corresponding cause bits in the same cycle.
REQ-027 A trip SHALL take priority over start and over integ_setup_done in the same cycle.
REQ-028 TRIPPED SHALL be terminal until reset: shutdown=1, running=0, integ_enable=0; trip_cause SHALL be frozen, with later sources ignored.

Reset
REQ-029 aresetn low at a clock edge SHALL force IDLE and zero integ_enable, integ_window, integ_threshold, running, shutdown, trip_cause and the timeout counter, from any state including mid-ARMING or TRIPPED.

Configuration
REQ-030 With macro INTEGRATOR_SUPERVISOR_SETUP_TIMEOUT_EN defined, a down-counter SHALL load SETUP_TIMEOUT-1 on entering ARMING and decrement each ARMING cycle; at zero without integ_setup_done, it SHALL set trip_cause[5] and go to TRIPPED.
REQ-031 setup_done sampled high in the same cycle the timeout counter reaches zero SHALL go to ACTIVE (no timeout trip).
REQ-032 Without INTEGRATOR_SUPERVISOR_SETUP_TIMEOUT_EN, no counter SHALL exist, trip_cause[5] SHALL be tied 0, and ARMING SHALL wait indefinitely.

Structure
REQ-033 Package integrator_supervisor_pkg SHALL hold the state enum, the trip_cause bit-index constants and the MIN_WINDOW default.
REQ-034 The block SHALL be a single flat module with no sub-module.

Verification
REQ-035 Bench SHALL cover: start, window 4096, threshold 100 -> CONFIG 1 cycle; integ_enable high next cycle; setup_done at cycle 10 -> running=1 after the next edge.
REQ-036 Bench SHALL cover: start with window 2047 -> trip_cause=6'b010000, shutdown=1 after 1 edge, integ_enable never high.
REQ-037 Bench SHALL cover: ACTIVE, integ_over_threshold and ext_trip high in the same cycle -> trip_cause=6'b001001, running=0 and shutdown=1 after 1 edge; a later integ_err_overflow leaves trip_cause unchanged.
REQ-038 Bench SHALL cover: macro defined, SETUP_TIMEOUT=16, setup_done never asserted -> TRIPPED after 16 ARMING cycles with trip_cause[5]=1; macro undefined -> still ARMING after 1000 cycles.
REQ-039 Bench SHALL cover: aresetn low for 1 cycle in TRIPPED -> all outputs zero, state IDLE; a new start arms normally.
